escape_time_engine: RTL and testbench
=====================================

// Module: escape_time_engine
// PURPOSE
//   Parametrised escape-time iteration engine for the fractal renderer; successor to the single-mode Julia core.
//   Supports runtime Julia/Mandelbrot mode, a valid/ready pixel stream with tag passthrough,
//   a parametrised escape radius and saturating fixed-point arithmetic.
//   Sits between the pixel-coordinate generator (upstream) and the colour mapper (downstream).
//   Performs one z = z^2 + c iteration per clock.
// PARAMETERS
//   INTEGER_BITS    8   integer bits of signed fixed-point coordinates (incl. sign)
//   FRACTIONAL_BITS 24  fractional bits; DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS
//   MAX_ITER_WIDTH  16  width of iteration count and limit
//   TAG_WIDTH       16  width of opaque pixel tag carried from input to output
//   ESCAPE_R2       4   escape threshold on |z|^2, integer units (compare vs ESCAPE_R2 << FRACTIONAL_BITS)
// PORTS
//   clk_i       in   1               clock, all logic on rising edge
//   rst_i       in   1               asynchronous active-high reset
//   mode_i      in   1               0 = Julia (z0 = px+i*py, c = cx+i*cy); 1 = Mandelbrot (z0 = 0, c = px+i*py)
//   in_valid_i  in   1               pixel request valid
//   in_ready_o  out  1               engine can accept a request
//   px_i, py_i  in   DATA_WIDTH      signed pixel coordinate
//   cx_i, cy_i  in   DATA_WIDTH      signed Julia constant (ignored in Mandelbrot mode)
//   max_iter_i  in   MAX_ITER_WIDTH  iteration limit
//   tag_i       in   TAG_WIDTH       opaque pixel tag
//   out_valid_o out  1               result valid
//   out_ready_i in   1               downstream accepts result
//   iter_o      out  MAX_ITER_WIDTH  number of z updates applied before termination
//   escaped_o   out  1               1 = escaped; 0 = hit max_iter
//   tag_o       out  TAG_WIDTH       tag captured with the request
// BEHAVIOUR
//   - Reset: state IDLE; in_ready_o=1; out_valid_o=0; iter_o=0; escaped_o=0; tag_o=0; all internal z/c/iter/limit registers = 0.
//   - Reset is asynchronous, may assert mid-operation; any in-flight pixel is discarded, no result emitted.
//   - FSM: IDLE -> ITER -> DONE -> IDLE.
//   - in_ready_o = (state == IDLE); out_valid_o = (state == DONE).
//   - IDLE: on in_valid_i & in_ready_o, capture all of these, then go to ITER with iter = 0:
//     - mode-resolved z0 and c
//     - max_iter_i, tag_i
//   - Inputs are sampled only at accept. Later input changes do not affect the pixel in flight.
//   - ITER, per cycle, priority order:
//     - (a) |z|^2 >= ESCAPE_R2 << FRACTIONAL_BITS -> DONE, escaped=1
//     - (b) else iter == max_iter -> DONE, escaped=0
//     - (c) else z <= z^2 + c, iter <= iter + 1
//   - Latency: out_valid_o rises iter_o + 1 clocks after the accept edge.
//   - max_iter = 0: exactly one check cycle; iter_o = 0; escaped_o = escape of z0.
//   - DONE: outputs held stable while out_valid_o & !out_ready_i. On handshake go to IDLE.
//   - No same-cycle accept in DONE: minimum 1 idle cycle between result handshake and the next accept.
//   - Arithmetic, products:
//     - x*x, y*y, x*y computed at 2*DATA_WIDTH, then arithmetic shift right by FRACTIONAL_BITS
//     - saturated to the signed DATA_WIDTH range
//   - Arithmetic, updates:
//     - x' = x2 - y2 + cx
//     - y' = 2*xy + cy
//     - each add/sub saturates to the signed DATA_WIDTH range; no wrap-around
//   - Escape compare: x2 + y2 evaluated unsigned at DATA_WIDTH+1 bits (cannot overflow).
//   - A saturated square always satisfies the escape compare for default parameters.
//   - iter_o cannot wrap: bounded by max_iter_i <= 2^MAX_ITER_WIDTH - 1.
// CONFIGURATION
//   FRACTAL_SMOOTH_EN defined:
//     - adds output port mag2_o [DATA_WIDTH:0]: |z|^2 at the terminating check, for smooth colouring
//     - reset value 0; held with the other outputs in DONE
//   FRACTAL_SMOOTH_EN undefined:
//     - port and its register absent
//     - all other behaviour identical
// TESTING (Q8.24, defaults)
//   - Mandelbrot, px=py=0, max_iter=100 -> iter_o=100, escaped_o=0, out_valid 101 clocks after accept.
//   - Mandelbrot, px=2.0 (0x02000000), py=0, max_iter=50 -> iter_o=1, escaped_o=1; smooth: mag2_o=4.0.
//   - Julia, px=3.0, py=0, c=(-0.8,0.156), max_iter=50 -> iter_o=0, escaped_o=1, latency 1.
//   - max_iter=0, Mandelbrot, px=py=0 -> iter_o=0, escaped_o=0.
//   - Julia, px=py=0, c=(0.1,0.1), max_iter=20, out_ready_i low 5 clocks after out_valid:
//     - outputs and tag_o (0xBEEF) stable; in_ready_o=0 throughout
//     - completes on the ready edge
//   - Julia, px=127.9, py=127.9, c=0 -> squares saturate, iter_o=0, escaped_o=1.
//   - Reset during ITER at iter=10:
//     - out_valid_o=0, in_ready_o=1 immediately
//     - no stale result afterwards
//     - next pixel's result correct

Source files
------------

// File: rtl/escape_time_if.sv
// escape_time_if: pixel request / result bundle for escape_time_engine.
//   Request side : mode_i, in_valid_i, in_ready_o, px_i, py_i, cx_i, cy_i, max_iter_i, tag_i
//   Result side  : out_valid_o, out_ready_i, iter_o, escaped_o, tag_o
//   mag2_o       : |z|^2 at termination, present only when FRACTAL_SMOOTH_EN is defined
// modport slave is the engine's view, modport master is the upstream/downstream view.
interface escape_time_if #(
  parameter int unsigned INTEGER_BITS    = 8,
  parameter int unsigned FRACTIONAL_BITS = 24,
  parameter int unsigned MAX_ITER_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH       = 16
);
  localparam int unsigned DW = INTEGER_BITS + FRACTIONAL_BITS;

  logic                      mode_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [DW-1:0]             px_i;
  logic [DW-1:0]             py_i;
  logic [DW-1:0]             cx_i;
  logic [DW-1:0]             cy_i;
  logic [MAX_ITER_WIDTH-1:0] max_iter_i;
  logic [TAG_WIDTH-1:0]      tag_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [MAX_ITER_WIDTH-1:0] iter_o;
  logic                      escaped_o;
  logic [TAG_WIDTH-1:0]      tag_o;
`ifdef FRACTAL_SMOOTH_EN
  logic [DW:0]               mag2_o;
`endif

  modport slave (
    input  mode_i, in_valid_i, px_i, py_i, cx_i, cy_i, max_iter_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, iter_o, escaped_o, tag_o
`ifdef FRACTAL_SMOOTH_EN
    , output mag2_o
`endif
  );

  modport master (
    output mode_i, in_valid_i, px_i, py_i, cx_i, cy_i, max_iter_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, iter_o, escaped_o, tag_o
`ifdef FRACTAL_SMOOTH_EN
    , input mag2_o
`endif
  );
endinterface

// File: rtl/escape_time_engine.sv
// escape_time_engine: Julia/Mandelbrot escape-time iterator, one z = z^2 + c step per clock.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset, discards any pixel in flight
//   bus   : escape_time_if.slave (request handshake, result handshake, tag passthrough)
// Optional feature: define FRACTAL_SMOOTH_EN to add bus.mag2_o (|z|^2 at the terminating check).
// Signed fixed-point Q(INTEGER_BITS).(FRACTIONAL_BITS); all arithmetic saturates.
module escape_time_engine #(
  parameter int unsigned INTEGER_BITS    = 8,
  parameter int unsigned FRACTIONAL_BITS = 24,
  parameter int unsigned MAX_ITER_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH       = 16,
  parameter int unsigned ESCAPE_R2       = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  escape_time_if.slave bus
);
  localparam int unsigned DW = INTEGER_BITS + FRACTIONAL_BITS;
  localparam int unsigned PW = 2 * DW;
  localparam logic [DW:0]    ESC_THR = (DW+1)'(ESCAPE_R2) << FRACTIONAL_BITS;
  localparam logic [DW-1:0]  VAL_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]  VAL_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  // Fixed-point product, rescaled and clamped to the DW-bit signed range.
  function automatic logic [DW-1:0] sat_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'($signed(a)) * PW'($signed(b));
    p = p >>> FRACTIONAL_BITS;
    if (p[PW-1:DW-1] == {(PW-DW+1){p[PW-1]}}) return p[DW-1:0];
    return p[PW-1] ? VAL_MIN : VAL_MAX;
  endfunction

  // Signed add/sub at DW+1 bits; a disagreement of the top two bits means overflow.
  function automatic logic [DW-1:0] sat_addsub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic sub);
    logic [DW:0] s;
    s = sub ? ({a[DW-1], a} - {b[DW-1], b}) : ({a[DW-1], a} + {b[DW-1], b});
    if (s[DW] == s[DW-1]) return s[DW-1:0];
    return s[DW] ? VAL_MIN : VAL_MAX;
  endfunction

  state_t                    state;
  logic [DW-1:0]             zx, zy, cx, cy;
  logic [MAX_ITER_WIDTH-1:0] iter, limit;
  logic                      in_ready_q, out_valid_q, escaped_q;
  logic [MAX_ITER_WIDTH-1:0] iter_q;
  logic [TAG_WIDTH-1:0]      tag_cap, tag_q;
  logic [DW:0]               mag2_q;

  // One iteration step computed from the current z.
  logic [DW-1:0] x2, y2, xy, nx, ny;
  logic [DW:0]   mag2;
  always_comb begin
    x2   = sat_mul(zx, zx);
    y2   = sat_mul(zy, zy);
    xy   = sat_mul(zx, zy);
    // Squares are never negative, so zero-extension gives an exact unsigned sum.
    mag2 = {1'b0, x2} + {1'b0, y2};
    nx   = sat_addsub(sat_addsub(x2, y2, 1'b1), cx, 1'b0);
    ny   = sat_addsub(sat_addsub(xy, xy, 1'b0), cy, 1'b0);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      zx          <= '0;
      zy          <= '0;
      cx          <= '0;
      cy          <= '0;
      iter        <= '0;
      limit       <= '0;
      tag_cap     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      escaped_q   <= 1'b0;
      iter_q      <= '0;
      tag_q       <= '0;
      mag2_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid_i) begin
            if (bus.mode_i) begin
              zx <= '0;
              zy <= '0;
              cx <= bus.px_i;
              cy <= bus.py_i;
            end else begin
              zx <= bus.px_i;
              zy <= bus.py_i;
              cx <= bus.cx_i;
              cy <= bus.cy_i;
            end
            limit      <= bus.max_iter_i;
            tag_cap    <= bus.tag_i;
            iter       <= '0;
            in_ready_q <= 1'b0;
            state      <= S_ITER;
          end
        end
        S_ITER: begin
          if (mag2 >= ESC_THR || iter == limit) begin
            escaped_q   <= (mag2 >= ESC_THR);
            iter_q      <= iter;
            tag_q       <= tag_cap;
            mag2_q      <= mag2;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end else begin
            zx   <= nx;
            zy   <= ny;
            iter <= iter + MAX_ITER_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.iter_o      = iter_q;
  assign bus.escaped_o   = escaped_q;
  assign bus.tag_o       = tag_q;

`ifdef FRACTAL_SMOOTH_EN
  assign bus.mag2_o = mag2_q;
`else
  // Without the smooth-colouring port the captured magnitude has no reader.
  logic unused_mag2;
  assign unused_mag2 = ^mag2_q;
`endif
endmodule

// File: tb/tb_escape_time_engine.sv
// tb_escape_time_engine: directed checks of escape_time_engine in Q8.24 default configuration.
module tb_escape_time_engine;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   lat;
  int   stale;

  escape_time_if bus ();

  escape_time_engine dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Issue one pixel, scramble inputs after accept, then count clocks until out_valid.
  task automatic run_pixel(input logic mode, input logic [31:0] px, input logic [31:0] py,
                           input logic [31:0] cx, input logic [31:0] cy,
                           input logic [15:0] max_iter, input logic [15:0] tag,
                           output int latency);
    @(negedge clk);
    bus.mode_i     = mode;
    bus.px_i       = px;
    bus.py_i       = py;
    bus.cx_i       = cx;
    bus.cy_i       = cy;
    bus.max_iter_i = max_iter;
    bus.tag_i      = tag;
    bus.in_valid_i = 1'b1;
    chk("in_ready_before_accept", 64'(bus.in_ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.mode_i     = ~mode;
    bus.px_i       = 32'h7F00_0000;
    bus.py_i       = 32'h8100_0000;
    bus.cx_i       = 32'h1234_5678;
    bus.cy_i       = 32'h8765_4321;
    bus.max_iter_i = 16'hFFFF;
    bus.tag_i      = 16'h5A5A;
    latency = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      latency++;
      if (bus.out_valid_o) break;
    end
    chk("result_within_bound", 64'(bus.out_valid_o), 64'd1);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("out_valid_after_handshake", 64'(bus.out_valid_o), 64'd0);
    chk("in_ready_after_handshake", 64'(bus.in_ready_o), 64'd1);
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    bus.mode_i     = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.px_i       = '0;
    bus.py_i       = '0;
    bus.cx_i       = '0;
    bus.cy_i       = '0;
    bus.max_iter_i = '0;
    bus.tag_i      = '0;
    bus.out_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_iter", 64'(bus.iter_o), 64'd0);
    chk("rst_escaped", 64'(bus.escaped_o), 64'd0);
    chk("rst_tag", 64'(bus.tag_o), 64'd0);
`ifdef FRACTAL_SMOOTH_EN
    chk("rst_mag2", 64'(bus.mag2_o), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Mandelbrot origin never escapes: full 100 iterations.
    run_pixel(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd100, 16'h0001, lat);
    chk("mand0_latency", 64'(lat), 64'd101);
    chk("mand0_iter", 64'(bus.iter_o), 64'd100);
    chk("mand0_escaped", 64'(bus.escaped_o), 64'd0);
    chk("mand0_tag", 64'(bus.tag_o), 64'h0001);
    handshake();

    // Mandelbrot c=2.0: z becomes 2.0 after one update, |z|^2 = 4.0 escapes.
    run_pixel(1'b1, 32'h0200_0000, 32'h0, 32'h0, 32'h0, 16'd50, 16'h0002, lat);
    chk("mand2_latency", 64'(lat), 64'd2);
    chk("mand2_iter", 64'(bus.iter_o), 64'd1);
    chk("mand2_escaped", 64'(bus.escaped_o), 64'd1);
`ifdef FRACTAL_SMOOTH_EN
    chk("mand2_mag2", 64'(bus.mag2_o), 64'h0400_0000);
`endif
    handshake();

    // Julia z0=3.0 escapes at the first check.
    run_pixel(1'b0, 32'h0300_0000, 32'h0, 32'hFF33_3333, 32'h0027_EF9E, 16'd50, 16'h0003, lat);
    chk("julia3_latency", 64'(lat), 64'd1);
    chk("julia3_iter", 64'(bus.iter_o), 64'd0);
    chk("julia3_escaped", 64'(bus.escaped_o), 64'd1);
`ifdef FRACTAL_SMOOTH_EN
    chk("julia3_mag2", 64'(bus.mag2_o), 64'h0900_0000);
`endif
    handshake();

    // max_iter = 0: single check cycle.
    run_pixel(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0, 16'h0004, lat);
    chk("maxit0_latency", 64'(lat), 64'd1);
    chk("maxit0_iter", 64'(bus.iter_o), 64'd0);
    chk("maxit0_escaped", 64'(bus.escaped_o), 64'd0);
    handshake();

    // Julia c=(0.1,0.1) from origin stays bounded; hold off the result for 5 clocks.
    run_pixel(1'b0, 32'h0, 32'h0, 32'h0019_999A, 32'h0019_999A, 16'd20, 16'hBEEF, lat);
    chk("stall_latency", 64'(lat), 64'd21);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", 64'(bus.out_valid_o), 64'd1);
      chk("stall_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("stall_iter", 64'(bus.iter_o), 64'd20);
      chk("stall_escaped", 64'(bus.escaped_o), 64'd0);
      chk("stall_tag", 64'(bus.tag_o), 64'hBEEF);
    end
    handshake();

    // Saturated squares at 127.9 escape immediately.
    run_pixel(1'b0, 32'h7FE6_6666, 32'h7FE6_6666, 32'h0, 32'h0, 16'd50, 16'h0006, lat);
    chk("sat_latency", 64'(lat), 64'd1);
    chk("sat_iter", 64'(bus.iter_o), 64'd0);
    chk("sat_escaped", 64'(bus.escaped_o), 64'd1);
`ifdef FRACTAL_SMOOTH_EN
    chk("sat_mag2", 64'(bus.mag2_o), 64'h0_FFFF_FFFE);
`endif
    handshake();

    // Asynchronous reset while iterating at iter=10.
    @(negedge clk);
    bus.mode_i     = 1'b1;
    bus.px_i       = '0;
    bus.py_i       = '0;
    bus.max_iter_i = 16'd100;
    bus.tag_i      = 16'h0007;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("iter_in_ready", 64'(bus.in_ready_o), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid_o) stale++;
    end
    chk("no_stale_result", 64'(stale), 64'd0);
    run_pixel(1'b0, 32'h0300_0000, 32'h0, 32'h0, 32'h0, 16'd50, 16'h0008, lat);
    chk("post_rst_latency", 64'(lat), 64'd1);
    chk("post_rst_iter", 64'(bus.iter_o), 64'd0);
    chk("post_rst_escaped", 64'(bus.escaped_o), 64'd1);
    chk("post_rst_tag", 64'(bus.tag_o), 64'h0008);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
